execute_stage: RTL and testbench

//  EX stage of the 5-stage RV32I pipeline, directly downstream of the ALU control decoder.
//  - Consumes the 3-bit ALU control code and selects forwarded operands.
//  - Computes the ALU result and resolves BEQ/JAL redirection.
//  - Registers the results into the EX/MEM pipeline register.
//  - The register has stall (hold) and flush (bubble) control for the hazard unit.

---
 rtl/execute_stage_pkg.sv | 20 ++
 rtl/execute_stage_if.sv | 50 +++++
 rtl/execute_stage_alu.sv | 32 +++
 rtl/execute_stage.sv | 98 +++++++++
 tb/tb_execute_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared pipeline encodings for the RV32I EX stage: ALU control, forwarding selects
// and result-source codes.
package execute_stage_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // 2'b11 is reserved and treated like FWD_RF
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, plus the fetch redirect.
// master = upstream driver / consumer, slave = execute_stage.
interface execute_stage_if #(parameter int XLEN = 32);

  logic            i_valid;
  logic [2:0]      i_alu_ctl;
  logic            i_alu_src;
  logic [1:0]      i_fwd_a;
  logic [1:0]      i_fwd_b;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_mem_fwd_data;
  logic [XLEN-1:0] i_wb_fwd_data;
  logic [4:0]      i_rd;
  logic            i_reg_write;
  logic            i_mem_write;
  logic            i_branch;
  logic            i_jump;
  logic [1:0]      i_result_src;

  logic            o_pc_src;
  logic [XLEN-1:0] o_pc_target;
  logic            o_valid;
  logic            o_reg_write;
  logic            o_mem_write;
  logic [1:0]      o_result_src;
  logic [4:0]      o_rd;
  logic [XLEN-1:0] o_alu_result;
  logic [XLEN-1:0] o_write_data;
  logic [XLEN-1:0] o_pc_plus4;

  modport master (
    output i_valid, i_alu_ctl, i_alu_src, i_fwd_a, i_fwd_b, i_rs1_data, i_rs2_data,
           i_imm, i_pc, i_mem_fwd_data, i_wb_fwd_data, i_rd, i_reg_write,
           i_mem_write, i_branch, i_jump, i_result_src,
    input  o_pc_src, o_pc_target, o_valid, o_reg_write, o_mem_write, o_result_src,
           o_rd, o_alu_result, o_write_data, o_pc_plus4
  );

  modport slave (
    input  i_valid, i_alu_ctl, i_alu_src, i_fwd_a, i_fwd_b, i_rs1_data, i_rs2_data,
           i_imm, i_pc, i_mem_fwd_data, i_wb_fwd_data, i_rd, i_reg_write,
           i_mem_write, i_branch, i_jump, i_result_src,
    output o_pc_src, o_pc_target, o_valid, o_reg_write, o_mem_write, o_result_src,
           o_rd, o_alu_result, o_write_data, o_pc_plus4
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU: add/sub/and/or/slt, unused codes produce zero.
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_alu_ctl,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  logic [XLEN-1:0] w_result;

  // Operation select; slt compares signed and zero-extends the flag
  always_comb begin
    w_result = '0;
    case (i_alu_ctl)
      ALU_ADD: w_result = i_a + i_b;
      ALU_SUB: w_result = i_a - i_b;
      ALU_AND: w_result = i_a & i_b;
      ALU_OR:  w_result = i_a | i_b;
      ALU_SLT: w_result = ($signed(i_a) < $signed(i_b)) ? XLEN'(1) : '0;
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: operand forwarding, ALU, BEQ/JAL redirect and the EX/MEM register
// with hazard-unit stall/flush.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_stall,
  input  logic           i_flush,
  execute_stage_if.slave ex
);

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  logic            r_valid;
  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [XLEN-1:0] r_pc_plus4;

  // Forwarding muxes; the reserved select falls back to register-file data
  always_comb begin
    w_fwd_a = ex.i_rs1_data;
    w_fwd_b = ex.i_rs2_data;
    case (ex.i_fwd_a)
      FWD_MEM: w_fwd_a = ex.i_mem_fwd_data;
      FWD_WB:  w_fwd_a = ex.i_wb_fwd_data;
      default: w_fwd_a = ex.i_rs1_data;
    endcase
    case (ex.i_fwd_b)
      FWD_MEM: w_fwd_b = ex.i_mem_fwd_data;
      FWD_WB:  w_fwd_b = ex.i_wb_fwd_data;
      default: w_fwd_b = ex.i_rs2_data;
    endcase
  end

  assign w_op_b = ex.i_alu_src ? ex.i_imm : w_fwd_b;

  execute_stage_alu #(.XLEN(XLEN)) u_alu (
    .i_a       (w_fwd_a),
    .i_b       (w_op_b),
    .i_alu_ctl (ex.i_alu_ctl),
    .o_result  (w_alu_result),
    .o_zero    (w_zero)
  );

  assign ex.o_pc_src    = ex.i_valid & ((ex.i_branch & w_zero) | ex.i_jump);
  assign ex.o_pc_target = ex.i_pc + ex.i_imm;

  // EX/MEM register: reset > flush > stall > load; flush only clears the control bits
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_rd         <= 5'd0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= RESET_PC;
    end else if (i_flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!i_stall) begin
      r_valid      <= ex.i_valid;
      r_reg_write  <= ex.i_reg_write & ex.i_valid;
      r_mem_write  <= ex.i_mem_write & ex.i_valid;
      r_result_src <= ex.i_result_src;
      r_rd         <= ex.i_rd;
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_plus4   <= ex.i_pc + XLEN'(4);
    end else begin
      r_valid <= r_valid;
    end
  end

  assign ex.o_valid      = r_valid;
  assign ex.o_reg_write  = r_reg_write;
  assign ex.o_mem_write  = r_mem_write;
  assign ex.o_result_src = r_result_src;
  assign ex.o_rd         = r_rd;
  assign ex.o_alu_result = r_alu_result;
  assign ex.o_write_data = r_write_data;
  assign ex.o_pc_plus4   = r_pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;
  int   n_total = 0;
  int   n_bad   = 0;

  execute_stage_if #(.XLEN(32)) ex ();

  execute_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_stall (stall),
    .i_flush (flush),
    .ex      (ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex.i_valid = 1'b0;        ex.i_alu_ctl = 3'b000;   ex.i_alu_src = 1'b0;
    ex.i_fwd_a = 2'b00;       ex.i_fwd_b = 2'b00;
    ex.i_rs1_data = 32'h0;    ex.i_rs2_data = 32'h0;   ex.i_imm = 32'h0;
    ex.i_pc = 32'h0;          ex.i_mem_fwd_data = 32'h0; ex.i_wb_fwd_data = 32'h0;
    ex.i_rd = 5'd0;           ex.i_reg_write = 1'b0;   ex.i_mem_write = 1'b0;
    ex.i_branch = 1'b0;       ex.i_jump = 1'b0;        ex.i_result_src = 2'b00;
  endtask

  task automatic alu_vec(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    ex.i_valid = 1'b1; ex.i_alu_ctl = ctl; ex.i_rs1_data = a; ex.i_rs2_data = b;
    ex.i_rd = 5'd3;    ex.i_reg_write = 1'b1; ex.i_pc = 32'h40;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    idle_inputs();
    #1;
    step(); step();
    chk("rst_valid", {31'd0, ex.o_valid}, 32'd0);
    chk("rst_regw",  {31'd0, ex.o_reg_write}, 32'd0);
    chk("rst_memw",  {31'd0, ex.o_mem_write}, 32'd0);
    chk("rst_rsrc",  {30'd0, ex.o_result_src}, 32'd0);
    chk("rst_rd",    {27'd0, ex.o_rd}, 32'd0);
    chk("rst_alu",   ex.o_alu_result, 32'd0);
    chk("rst_wdata", ex.o_write_data, 32'd0);
    chk("rst_pc4",   ex.o_pc_plus4, RST_PC);
    rst_n = 1'b1;

    // ALU ops without forwarding
    alu_vec(3'b000, 32'd7, 32'd5); ex.i_result_src = 2'b10;
    step();
    chk("add", ex.o_alu_result, 32'd12);
    chk("add_valid", {31'd0, ex.o_valid}, 32'd1);
    chk("add_regw", {31'd0, ex.o_reg_write}, 32'd1);
    chk("add_rd", {27'd0, ex.o_rd}, 32'd3);
    chk("add_pc4", ex.o_pc_plus4, 32'h44);
    chk("add_rsrc", {30'd0, ex.o_result_src}, 32'd2);
    chk("add_wdata", ex.o_write_data, 32'd5);
    alu_vec(3'b001, 32'd5, 32'd7);          step(); chk("sub", ex.o_alu_result, 32'hFFFF_FFFE);
    alu_vec(3'b010, 32'hF0, 32'h3C);        step(); chk("and", ex.o_alu_result, 32'h30);
    alu_vec(3'b011, 32'hF0, 32'h0F);        step(); chk("or",  ex.o_alu_result, 32'hFF);
    alu_vec(3'b101, 32'hFFFF_FFFF, 32'd1);  step(); chk("slt_neg", ex.o_alu_result, 32'd1);
    alu_vec(3'b101, 32'd1, 32'hFFFF_FFFF);  step(); chk("slt_pos", ex.o_alu_result, 32'd0);

    // Forwarding
    alu_vec(3'b000, 32'd1, 32'd2);
    ex.i_fwd_a = 2'b10; ex.i_mem_fwd_data = 32'd100;
    ex.i_fwd_b = 2'b01; ex.i_wb_fwd_data = 32'd23;
    step();
    chk("fwd_add", ex.o_alu_result, 32'd123);
    chk("fwd_wdata", ex.o_write_data, 32'd23);
    ex.i_alu_src = 1'b1; ex.i_imm = 32'd4;
    step();
    chk("fwd_imm_alu", ex.o_alu_result, 32'd104);
    chk("fwd_imm_wdata", ex.o_write_data, 32'd23);
    ex.i_fwd_a = 2'b11; ex.i_fwd_b = 2'b11; ex.i_alu_src = 1'b0;
    step();
    chk("fwd_reserved", ex.o_alu_result, 32'd3);

    // Branch and jump redirect (combinational)
    alu_vec(3'b001, 32'd9, 32'd9);
    ex.i_branch = 1'b1; ex.i_pc = 32'h100; ex.i_imm = 32'h20; ex.i_reg_write = 1'b0;
    #1;
    chk("beq_taken", {31'd0, ex.o_pc_src}, 32'd1);
    chk("beq_target", ex.o_pc_target, 32'h120);
    ex.i_rs2_data = 32'd8; #1;
    chk("beq_not_taken", {31'd0, ex.o_pc_src}, 32'd0);
    ex.i_rs2_data = 32'd9; ex.i_valid = 1'b0; #1;
    chk("beq_invalid", {31'd0, ex.o_pc_src}, 32'd0);
    ex.i_valid = 1'b1; ex.i_branch = 1'b0; ex.i_jump = 1'b1; ex.i_rs2_data = 32'd1; #1;
    chk("jal", {31'd0, ex.o_pc_src}, 32'd1);
    ex.i_pc = 32'hFFFF_FFF0; #1;
    chk("target_wrap", ex.o_pc_target, 32'h10);

    // Invalid instruction gates write enables; rd=x0 keeps reg_write
    alu_vec(3'b000, 32'd1, 32'd1); ex.i_valid = 1'b0; ex.i_mem_write = 1'b1;
    step();
    chk("inv_valid", {31'd0, ex.o_valid}, 32'd0);
    chk("inv_regw", {31'd0, ex.o_reg_write}, 32'd0);
    chk("inv_memw", {31'd0, ex.o_mem_write}, 32'd0);
    alu_vec(3'b000, 32'd1, 32'd1); ex.i_rd = 5'd0;
    step();
    chk("x0_regw", {31'd0, ex.o_reg_write}, 32'd1);

    // Stall holds, flush with stall clears control bits
    alu_vec(3'b000, 32'd7, 32'd5); ex.i_mem_write = 1'b1;
    step();
    chk("pre_stall", ex.o_alu_result, 32'd12);
    stall = 1'b1;
    alu_vec(3'b011, 32'hAA, 32'h55); ex.i_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu", ex.o_alu_result, 32'd12);
      chk("stall_valid", {31'd0, ex.o_valid}, 32'd1);
      chk("stall_memw", {31'd0, ex.o_mem_write}, 32'd1);
      chk("stall_pc4", ex.o_pc_plus4, 32'h44);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex.o_valid}, 32'd0);
    chk("flush_regw", {31'd0, ex.o_reg_write}, 32'd0);
    chk("flush_memw", {31'd0, ex.o_mem_write}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("post_flush", ex.o_alu_result, 32'hFF);

    // Reset mid-stall with a valid instruction present
    alu_vec(3'b000, 32'd20, 32'd22); ex.i_mem_write = 1'b1; ex.i_result_src = 2'b01;
    stall = 1'b1; rst_n = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, ex.o_valid}, 32'd0);
    chk("mid_rst_regw", {31'd0, ex.o_reg_write}, 32'd0);
    chk("mid_rst_memw", {31'd0, ex.o_mem_write}, 32'd0);
    chk("mid_rst_alu", ex.o_alu_result, 32'd0);
    chk("mid_rst_rd", {27'd0, ex.o_rd}, 32'd0);
    chk("mid_rst_pc4", ex.o_pc_plus4, RST_PC);
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("resume_alu", ex.o_alu_result, 32'd42);
    chk("resume_memw", {31'd0, ex.o_mem_write}, 32'd1);
    chk("resume_rsrc", {30'd0, ex.o_result_src}, 32'd1);

    // Unused ALU code yields zero, which satisfies a branch
    alu_vec(3'b111, 32'd5, 32'd3); ex.i_branch = 1'b1;
    #1;
    chk("illegal_pc_src", {31'd0, ex.o_pc_src}, 32'd1);
    step();
    chk("illegal_alu", ex.o_alu_result, 32'd0);
    alu_vec(3'b100, 32'd5, 32'd3);
    step();
    chk("code100_alu", ex.o_alu_result, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
